// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths, the x0 address constant and the queue entry type for the write-back scheduler.
package regfile_wb_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;
   localparam int ZERO_REG   = 0;

   typedef struct packed {
      logic                  valid;
      logic [REG_AW_DEF-1:0] rd;
      logic [XLEN_DEF-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Retiring-result stream (valid/ready) from execute/load completion into the write-back scheduler.
import regfile_wb_pkg::*;

interface regfile_write_scheduler_if #(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
);
   logic              in_valid;
   logic              in_ready;
   logic [REG_AW-1:0] in_rd;
   logic [XLEN-1:0]   in_data;

   modport master (output in_valid, output in_rd, output in_data, input in_ready);
   modport slave  (input in_valid, input in_rd, input in_data, output in_ready);
endinterface

// File: rtl/wb_entry_fifo.sv
// In-order entry queue: storage, wrapping pointers, occupancy and a flattened view for forwarding.
module wb_entry_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 37,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [W-1:0]       push_data,
   output logic [W-1:0]       head_data,
   output logic [CW-1:0]      count,
   output logic               full,
   output logic               empty,
   output logic [PW-1:0]      head_ptr,
   output logic [DEPTH-1:0]   ent_valid,
   output logic [DEPTH*W-1:0] ent_data
);

   logic [PW-1:0]    head_ptr_q, head_ptr_d;
   logic [PW-1:0]    tail_ptr_q, tail_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];

   logic do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block leaves a variable unassigned (no latch).
      head_ptr_d = head_ptr_q;
      tail_ptr_d = tail_ptr_q;
      count_d    = count_q;
      valid_d    = valid_q;
      mem_d      = mem_q;
      if (do_push) begin
         mem_d[tail_ptr_q]   = push_data;
         valid_d[tail_ptr_q] = 1'b1;
         tail_ptr_d          = tail_ptr_q + PW'(1);
      end
      if (do_pop) begin
         valid_d[head_ptr_q] = 1'b0;
         head_ptr_d          = head_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
      if (!rst_n) begin
         head_ptr_q <= '0;
         tail_ptr_q <= '0;
         count_q    <= '0;
         valid_q    <= '0;
      end else begin
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
      end
   end

   // NOTE: payload storage is deliberately not reset; valid bits and the empty gate make stale data invisible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      ent_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_data[i*W +: W] = mem_q[i];
      end
   end

   assign head_data = mem_q[head_ptr_q];
   assign count     = count_q;
   assign head_ptr  = head_ptr_q;
   assign ent_valid = valid_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port initiator: x0 filter, in-order queue drain, optional forwarding (WB_FORWARD_EN).
import regfile_wb_pkg::*;

module regfile_write_scheduler #(
   parameter  int DEPTH  = 4,
   parameter  int XLEN   = XLEN_DEF,
   parameter  int REG_AW = REG_AW_DEF,
   localparam int PW     = $clog2(DEPTH),
   localparam int CW     = PW + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   regfile_write_scheduler_if.slave  in_if,
   input  logic                      drain_en,
   output logic                      RegWrite,
   output logic [REG_AW-1:0]         WriteRegister,
   output logic [XLEN-1:0]           WriteData,
   output logic [CW-1:0]             q_count,
   input  logic [REG_AW-1:0]         fwd_addr1,
   input  logic [REG_AW-1:0]         fwd_addr2,
   output logic                      fwd_hit1,
   output logic                      fwd_hit2,
   output logic [XLEN-1:0]           fwd_data1,
   output logic [XLEN-1:0]           fwd_data2
);

   localparam int W = REG_AW + XLEN;

   logic               push;
   logic [W-1:0]       head_data;
   logic               full, empty;
   logic [PW-1:0]      head_ptr;
   logic [DEPTH-1:0]   ent_valid;
   logic [DEPTH*W-1:0] ent_data;

   // Writes to x0 complete the handshake but never occupy a slot.
   assign in_if.in_ready = !full;
   assign push = in_if.in_valid && in_if.in_ready && (in_if.in_rd != REG_AW'(ZERO_REG));

   wb_entry_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (RegWrite),
      .push_data ({in_if.in_rd, in_if.in_data}),
      .head_data (head_data),
      .count     (q_count),
      .full      (full),
      .empty     (empty),
      .head_ptr  (head_ptr),
      .ent_valid (ent_valid),
      .ent_data  (ent_data)
   );

   assign RegWrite      = !empty && drain_en;
   assign WriteRegister = empty ? '0 : head_data[W-1 -: REG_AW];
   assign WriteData     = empty ? '0 : head_data[XLEN-1:0];

`ifdef WB_FORWARD_EN
   // Walk oldest to youngest from the head so the last match is the youngest value.
   function automatic logic [XLEN:0] fwd_lookup(
      input logic [REG_AW-1:0]  addr,
      input logic [PW-1:0]      hp,
      input logic [DEPTH-1:0]   vld,
      input logic [DEPTH*W-1:0] ents
   );
      logic [XLEN:0] res;
      logic [PW-1:0] idx;
      logic [W-1:0]  e;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = hp + PW'(i);
         e   = ents[int'(idx)*W +: W];
         if (addr != REG_AW'(ZERO_REG) && vld[idx] && e[W-1 -: REG_AW] == addr) begin
            res = {1'b1, e[XLEN-1:0]};
         end
      end
      return res;
   endfunction

   logic [XLEN:0] fwd1, fwd2;

   always_comb begin
      fwd1 = fwd_lookup(fwd_addr1, head_ptr, ent_valid, ent_data);
      fwd2 = fwd_lookup(fwd_addr2, head_ptr, ent_valid, ent_data);
   end

   assign fwd_hit1  = fwd1[XLEN];
   assign fwd_data1 = fwd1[XLEN-1:0];
   assign fwd_hit2  = fwd2[XLEN];
   assign fwd_data2 = fwd2[XLEN-1:0];
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_addr1, fwd_addr2, head_ptr, ent_valid, ent_data};
   assign fwd_hit1   = 1'b0;
   assign fwd_hit2   = 1'b0;
   assign fwd_data1  = '0;
   assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
import regfile_wb_pkg::*;

module tb_regfile_write_scheduler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        drain_en = 1'b0;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic [2:0]  q_count;
   logic [4:0]  fwd_addr1 = '0, fwd_addr2 = '0;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;

   int n_cmp  = 0;
   int n_fail = 0;

   regfile_write_scheduler_if #(.XLEN(32), .REG_AW(5)) bus ();

   regfile_write_scheduler #(.DEPTH(DEPTH), .XLEN(32), .REG_AW(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_if         (bus),
      .drain_en      (drain_en),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .q_count       (q_count),
      .fwd_addr1     (fwd_addr1),
      .fwd_addr2     (fwd_addr2),
      .fwd_hit1      (fwd_hit1),
      .fwd_hit2      (fwd_hit2),
      .fwd_data1     (fwd_data1),
      .fwd_data2     (fwd_data2)
   );

   always #5 clk = ~clk;

   // Reference model: pending writes, oldest at index 0.
   wb_entry_t model_q[$];
   logic      exp_push, exp_pop;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
`ifdef WB_FORWARD_EN
      if (a != 0) begin
         foreach (model_q[i]) begin
            if (model_q[i].rd == a) begin
               hit = 1'b1;
               d   = model_q[i].data;
            end
         end
      end
`endif
   endtask

   task automatic compare();
      logic        h;
      logic [31:0] d;
      logic        rdy, we;
      rdy = (model_q.size() < DEPTH);
      we  = (model_q.size() > 0) && drain_en;
      check("q_count", q_count, model_q.size());
      check("in_ready", bus.in_ready, rdy);
      check("RegWrite", RegWrite, we);
      check("WriteRegister", WriteRegister, model_q.size() > 0 ? model_q[0].rd : 5'd0);
      check("WriteData", WriteData, model_q.size() > 0 ? model_q[0].data : 32'd0);
      model_fwd(fwd_addr1, h, d);
      check("fwd_hit1", fwd_hit1, h);
      check("fwd_data1", fwd_data1, d);
      model_fwd(fwd_addr2, h, d);
      check("fwd_hit2", fwd_hit2, h);
      check("fwd_data2", fwd_data2, d);
      exp_pop  = we;
      exp_push = bus.in_valid && rdy && (bus.in_rd != 0);
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic de, input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_rd    = rd;
      bus.in_data  = d;
      drain_en     = de;
      fwd_addr1    = a1;
      fwd_addr2    = a2;
      #1;
      compare();
   endtask

   task automatic tick();
      wb_entry_t e;
      e.valid = 1'b1;
      e.rd    = bus.in_rd;
      e.data  = bus.in_data;
      @(posedge clk);
      if (exp_pop)  void'(model_q.pop_front());
      if (exp_push) model_q.push_back(e);
   endtask

   task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic de);
      drive(v, rd, d, de, 5'd0, 5'd0);
      tick();
   endtask

   task automatic drain_all();
      for (int i = 0; i < 2*DEPTH; i++) step(1'b0, 5'd0, 32'd0, 1'b1);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_rd    = '0;
      bus.in_data  = '0;
      #12;
      check("rst RegWrite", RegWrite, 0);
      check("rst q_count", q_count, 0);
      check("rst fwd_hit1", fwd_hit1, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      check("idle in_ready", bus.in_ready, 1);
      check("idle RegWrite", RegWrite, 0);
      check("idle q_count", q_count, 0);
      tick();

      // Single push, one-cycle latency to the write port.
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      check("single RegWrite", RegWrite, 1);
      check("single WriteRegister", WriteRegister, 5);
      check("single WriteData", WriteData, 32'hDEADBEEF);
      check("single q_count before", q_count, 1);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      check("single q_count after", q_count, 0);
      tick();

      // Fill while stalled, hold a fifth offer, then drain in order.
      for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'h100 + i, 1'b0);
      drive(1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 5'd0);
      check("full q_count", q_count, 4);
      check("full in_ready", bus.in_ready, 0);
      tick();
      drive(1'b1, 5'd9, 32'h900, 1'b1, 5'd0, 5'd0);
      check("full pop RegWrite", RegWrite, 1);
      check("full pop WriteRegister", WriteRegister, 1);
      check("full pop in_ready", bus.in_ready, 0);
      tick();
      drive(1'b1, 5'd9, 32'h900, 1'b1, 5'd0, 5'd0);
      check("after pop in_ready", bus.in_ready, 1);
      check("after pop WriteRegister", WriteRegister, 2);
      tick();
      drain_all();

      // x0 result: consumed, never stored or written.
      drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0);
      check("x0 in_ready", bus.in_ready, 1);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      check("x0 q_count", q_count, 0);
      check("x0 RegWrite", RegWrite, 0);
      tick();

      // Forwarding picks the youngest duplicate.
      step(1'b1, 5'd7, 32'h11, 1'b0);
      step(1'b1, 5'd7, 32'h22, 1'b0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
`ifdef WB_FORWARD_EN
      check("fwd youngest hit", fwd_hit1, 1);
      check("fwd youngest data", fwd_data1, 32'h22);
`else
      check("fwd disabled hit", fwd_hit1, 0);
`endif
      check("fwd x0 hit", fwd_hit2, 0);
      tick();
      drain_all();

      // Continuous push and pop across pointer wrap.
      step(1'b1, 5'd1, 32'hA000, 1'b1);
      for (int i = 0; i < 3*DEPTH; i++) begin
         drive(1'b1, 5'((i % 31) + 2), 32'hB000 + i, 1'b1, 5'd0, 5'd0);
         check("stream q_count", q_count, 1);
         check("stream RegWrite", RegWrite, 1);
         tick();
      end
      drain_all();

      // Random traffic with small rd range to exercise duplicates and forwarding.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         tick();
      end

      // Asynchronous reset mid-cycle with queued results.
      step(1'b1, 5'd3, 32'h33, 1'b0);
      step(1'b1, 5'd4, 32'h44, 1'b0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd4);
      #1;
      rst_n = 1'b0;
      #1;
      check("async RegWrite", RegWrite, 0);
      check("async q_count", q_count, 0);
      check("async WriteData", WriteData, 0);
      check("async fwd_hit1", fwd_hit1, 0);
      check("async fwd_data2", fwd_data2, 0);
      model_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
